button_conditioner: RTL and testbench

//  Input stage between the raw board buttons and the cellstorage movement logic.
//  Per button: 2-FF synchroniser, counter debouncer, then a press/auto-repeat FSM.

---
 rtl/button_conditioner.sv | 158 +++++++++++++++
 tb/tb_button_conditioner.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Button input conditioner: per-channel 2-FF synchroniser, counter debouncer and
// press/auto-repeat FSM. Outputs a debounced level plus one-cycle press/release
// pulses; all outputs are registered and cleared asynchronously by reset.
module button_conditioner #(
  parameter int unsigned N_BTN           = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 251750,
  parameter int unsigned REPEAT_DELAY    = 5035000,
  parameter int unsigned REPEAT_PERIOD   = 1258750,
  parameter bit          ACTIVE_LOW      = 1'b0
) (
  input  logic             clk_25_175,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_BTN-1:0] repeat_en,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  // Debounce counter tops out at DEBOUNCE_CYCLES-1; repeat counter at the larger interval minus one.
  localparam int unsigned REPEAT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned CNT_W      = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned RCNT_W     = $clog2(REPEAT_MAX);

  // Count parameters below 2 would make the counters degenerate.
  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_param
    $error("button_conditioner: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must all be >= 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_e;

  for (genvar ch = 0; ch < N_BTN; ch++) begin : g_ch

    logic              raw_pol_c;
    logic              s1_q, s1_d;
    logic              s2_q, s2_d;
    logic              stable_q, stable_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    state_e            state_q, state_d;
    logic [RCNT_W-1:0] rcnt_q, rcnt_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              rise_c, fall_c;

    // Normalise polarity so that 1 always means pressed.
    assign raw_pol_c = btn_raw[ch] ^ ACTIVE_LOW;

    // Synchroniser next values.
    always_comb begin
      s1_d = raw_pol_c;
      s2_d = s1_q;
    end

    // Debouncer: accept s2 only after it has differed from stable for DEBOUNCE_CYCLES cycles.
    always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (s2_q != stable_q) begin
        if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          stable_d = s2_q;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    // Edges of the debounced value, aligned with the edge that updates stable_q.
    assign rise_c = stable_d & ~stable_q;
    assign fall_c = stable_q & ~stable_d;

    // Press/repeat FSM next state and registered pulse outputs; release has priority.
    always_comb begin
      state_d   = state_q;
      rcnt_d    = rcnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (rise_c) begin
            press_d = 1'b1;
            rcnt_d  = '0;
            state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (fall_c) begin
            release_d = 1'b1;
            rcnt_d    = '0;
            state_d   = ST_IDLE;
          end else if (repeat_en[ch]) begin
            if (rcnt_q == RCNT_W'(REPEAT_DELAY - 1)) begin
              press_d = 1'b1;
              rcnt_d  = '0;
              state_d = ST_REPEAT;
            end else begin
              rcnt_d = rcnt_q + RCNT_W'(1);
            end
          end else begin
            rcnt_d = '0;
          end
        end
        ST_REPEAT: begin
          if (fall_c) begin
            release_d = 1'b1;
            rcnt_d    = '0;
            state_d   = ST_IDLE;
          end else if (!repeat_en[ch]) begin
            rcnt_d  = '0;
            state_d = ST_HOLD;
          end else if (rcnt_q == RCNT_W'(REPEAT_PERIOD - 1)) begin
            press_d = 1'b1;
            rcnt_d  = '0;
          end else begin
            rcnt_d = rcnt_q + RCNT_W'(1);
          end
        end
        default: begin
          rcnt_d  = '0;
          state_d = ST_IDLE;
        end
      endcase
    end

    // All channel state, cleared asynchronously by reset.
    always_ff @(posedge clk_25_175 or posedge reset) begin
      if (reset) begin
        s1_q      <= 1'b0;
        s2_q      <= 1'b0;
        stable_q  <= 1'b0;
        cnt_q     <= '0;
        state_q   <= ST_IDLE;
        rcnt_q    <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        s1_q      <= s1_d;
        s2_q      <= s2_d;
        stable_q  <= stable_d;
        cnt_q     <= cnt_d;
        state_q   <= state_d;
        rcnt_q    <= rcnt_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    assign btn_level[ch]   = stable_q;
    assign btn_press[ch]   = press_q;
    assign btn_release[ch] = release_q;

  end : g_ch

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short count parameters.
module tb_button_conditioner;

  logic       clk;
  logic       rst;
  logic [2:0] raw_a, ren_a, lvl_a, prs_a, rel_a;
  logic [2:0] raw_b, ren_b, lvl_b, prs_b, rel_b;
  logic [2:0] el, ep, er;
  int         checks;
  int         errors;

  button_conditioner #(
    .N_BTN(3), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3), .ACTIVE_LOW(1'b0)
  ) dut_a (
    .clk_25_175(clk), .reset(rst), .btn_raw(raw_a), .repeat_en(ren_a),
    .btn_level(lvl_a), .btn_press(prs_a), .btn_release(rel_a)
  );

  button_conditioner #(
    .N_BTN(3), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3), .ACTIVE_LOW(1'b1)
  ) dut_b (
    .clk_25_175(clk), .reset(rst), .btn_raw(raw_b), .repeat_en(ren_b),
    .btn_level(lvl_b), .btn_press(prs_b), .btn_release(rel_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int cyc, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s cycle %0d observed=%b expected=%b", tag, cyc, got, exp);
    end
  endtask

  task automatic chk_a(input string tag, input int cyc);
    chk({tag, "_level"},   cyc, lvl_a, el);
    chk({tag, "_press"},   cyc, prs_a, ep);
    chk({tag, "_release"}, cyc, rel_a, er);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    raw_a  = 3'b000;
    ren_a  = 3'b000;
    raw_b  = 3'b111;
    ren_b  = 3'b000;
    el = '0; ep = '0; er = '0;

    // Reset state, held in reset and just after release.
    for (int i = 0; i < 4; i++) begin
      if (i == 2) rst = 1'b0;
      tick();
      chk_a("reset_a", i);
      chk("reset_b_level", i, lvl_b, 3'b000);
      chk("reset_b_press", i, prs_b, 3'b000);
    end

    // 1: channel 0 press without repeat, release after 20 held cycles.
    raw_a = 3'b001;
    for (int i = 0; i < 30; i++) begin
      if (i == 20) raw_a = 3'b000;
      tick();
      el = {2'b00, (i >= 5 && i < 25)};
      ep = {2'b00, (i == 5)};
      er = {2'b00, (i == 25)};
      chk_a("s1", i);
    end

    // 2: channel 1 bounces with 2-cycle pulses; nothing must be reported.
    el = '0; ep = '0; er = '0;
    for (int i = 0; i < 20; i++) begin
      raw_a = (i < 12 && ((i / 2) % 2 == 0)) ? 3'b010 : 3'b000;
      tick();
      chk_a("s2", i);
    end

    // 3: channel 2 auto-repeat; release coincides with a repeat expiry at edge 36.
    ren_a = 3'b100;
    raw_a = 3'b100;
    for (int i = 0; i < 41; i++) begin
      if (i == 31) raw_a = 3'b000;
      tick();
      el = {(i >= 5 && i < 36), 2'b00};
      ep = {(i == 5 || (i >= 15 && i < 36 && (i - 15) % 3 == 0)), 2'b00};
      er = {(i == 36), 2'b00};
      chk_a("s3", i);
    end

    // 4: repeat_en dropped (sampled at 17) then re-raised (sampled at 26).
    raw_a = 3'b100;
    for (int i = 0; i < 50; i++) begin
      if (i == 17) ren_a = 3'b000;
      if (i == 26) ren_a = 3'b100;
      if (i == 40) raw_a = 3'b000;
      tick();
      el = {(i >= 5 && i < 45), 2'b00};
      ep = {(i == 5 || i == 15 || (i >= 35 && i < 45 && (i - 35) % 3 == 0)), 2'b00};
      er = {(i == 45), 2'b00};
      chk_a("s4", i);
    end

    // 5: active-low instance, all pressed together, staggered release.
    raw_b = 3'b000;
    for (int i = 0; i < 26; i++) begin
      if (i == 10) raw_b[0] = 1'b1;
      if (i == 14) raw_b[1] = 1'b1;
      if (i == 18) raw_b[2] = 1'b1;
      tick();
      el = {(i >= 5 && i < 23), (i >= 5 && i < 19), (i >= 5 && i < 15)};
      ep = (i == 5) ? 3'b111 : 3'b000;
      er = {(i == 23), (i == 19), (i == 15)};
      chk("s5_level",   i, lvl_b, el);
      chk("s5_press",   i, prs_b, ep);
      chk("s5_release", i, rel_b, er);
    end

    // 6: reset pulsed while channel 2 is auto-repeating; fresh press afterwards.
    ren_a = 3'b100;
    raw_a = 3'b100;
    for (int i = 0; i < 18; i++) begin
      tick();
      el = {(i >= 5), 2'b00};
      ep = {(i == 5 || i == 15), 2'b00};
      er = 3'b000;
      chk_a("s6_pre", i);
    end
    rst = 1'b1;
    #1;
    el = '0; ep = '0; er = '0;
    chk_a("s6_async_reset", 17);
    for (int i = 18; i < 20; i++) begin
      tick();
      chk_a("s6_in_reset", i);
    end
    rst = 1'b0;
    for (int i = 20; i < 48; i++) begin
      if (i == 41) raw_a = 3'b000;
      tick();
      el = {(i >= 25 && i < 46), 2'b00};
      ep = {(i == 25 || (i >= 35 && i < 46 && (i - 35) % 3 == 0)), 2'b00};
      er = {(i == 46), 2'b00};
      chk_a("s6_post", i);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
